// File: rtl/timer_pkg.sv
// Shared state encoding for timer_controller and anything decoding its state_o output.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_RUN   = 2'd1;
  localparam logic [1:0] STATE_PAUSE = 2'd2;
  localparam logic [1:0] STATE_DONE  = 2'd3;

  function automatic logic is_active(input timer_state_t s);
    return (s == RUN) || (s == PAUSE);
  endfunction

endpackage

// File: rtl/timer_controller_prescaler.sv
// Clock prescaler: tick is high on the last phase of every DIV enabled cycles.
// The phase only advances while en is high, so a paused run resumes in the same phase.
module prescaler #(
  parameter int DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] phase_reg;

  // Ungated so the controller can combine it with its own enable without a comb loop.
  assign tick = (phase_reg == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_reg <= '0;
    end else if (clr) begin
      phase_reg <= '0;
    end else if (en) begin
      phase_reg <= (phase_reg == LAST) ? '0 : phase_reg + 1'b1;
    end
  end

endmodule

// File: rtl/timer_controller.sv
// Programmable one-shot timer around an N-bit up-counter with prescaler, hold and abort.
// Define TIMER_AUTORELOAD_EN to add the periodic input (auto-reload on terminal tick).
module timer_controller
  import timer_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIV = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] period_in,
  input  logic         hold,
  input  logic         abort,
`ifdef TIMER_AUTORELOAD_EN
  input  logic         periodic,
`endif
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state_o
);

  timer_state_t state_reg, state_next;
  logic [N-1:0] count_reg, count_next;
  logic [N-1:0] period_reg, period_next;
  logic         done_reg, done_next;
  logic         presc_clr, presc_en, tick;
  logic         load_ok, terminal, reload;

  prescaler #(.DIV(DIV)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clr   (presc_clr),
    .en    (presc_en),
    .tick  (tick)
  );

`ifdef TIMER_AUTORELOAD_EN
  assign reload = periodic;
`else
  assign reload = 1'b0;
`endif

  assign load_ok  = start && (period_in != '0);
  assign terminal = (count_reg == period_reg - 1'b1);

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    period_next = period_reg;
    done_next   = 1'b0;
    presc_clr   = 1'b0;
    presc_en    = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (abort) begin
          state_next = IDLE;
          count_next = '0;
          presc_clr  = 1'b1;
        end else if (load_ok) begin
          state_next  = RUN;
          period_next = period_in;
          count_next  = '0;
          presc_clr   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
          count_next = '0;
          presc_clr  = 1'b1;
        end else if (hold) begin
          state_next = PAUSE;
        end else begin
          presc_en = 1'b1;
          if (tick) begin
            if (terminal) begin
              done_next = 1'b1;
              if (reload) count_next = '0;
              else        state_next = DONE;
            end else begin
              count_next = count_reg + 1'b1;
            end
          end
        end
      end
      PAUSE: begin
        if (abort) begin
          state_next = IDLE;
          count_next = '0;
          presc_clr  = 1'b1;
        end else if (!hold) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
        presc_clr  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      period_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      period_reg <= period_next;
      done_reg   <= done_next;
    end
  end

  assign count   = count_reg;
  assign done    = done_reg;
  assign busy    = is_active(state_reg);
  assign state_o = state_reg;

endmodule

// File: tb/tb_timer_controller.sv
// Bench for timer_controller: DIV=1 and DIV=4 instances share stimulus; an elapsed-time
// reference model (count = run cycles / DIV) checks random traffic, directed tasks check corners.
module tb_timer_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0, start = 1'b0, hold = 1'b0, abort = 1'b0, periodic = 1'b0;
  logic [7:0] period_in = 8'd0;
  logic [7:0] c1, c4;
  logic       busy1, busy4, done1, done4;
  logic [1:0] st1, st4;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: state code, enabled run cycles elapsed, latched period, done pulse.
  int m_st[2];
  int m_e[2];
  int m_per[2];
  bit m_done[2];
  int m_div[2] = '{1, 4};

  always #5 clock = ~clock;

  timer_controller #(.N(8), .DIV(1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .period_in(period_in),
    .hold(hold), .abort(abort),
`ifdef TIMER_AUTORELOAD_EN
    .periodic(periodic),
`endif
    .count(c1), .busy(busy1), .done(done1), .state_o(st1)
  );

  timer_controller #(.N(8), .DIV(4)) dut4 (
    .clock(clock), .reset(reset), .start(start), .period_in(period_in),
    .hold(hold), .abort(abort),
`ifdef TIMER_AUTORELOAD_EN
    .periodic(periodic),
`endif
    .count(c4), .busy(busy4), .done(done4), .state_o(st4)
  );

  function automatic int exp_count(input int i);
    int r;
    if (m_st[i] == 0) return 0;
    r = m_e[i] / m_div[i];
    if (r > m_per[i] - 1) r = m_per[i] - 1;
    return r;
  endfunction

  task automatic model_step();
    bit per_en;
`ifdef TIMER_AUTORELOAD_EN
    per_en = periodic;
`else
    per_en = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (reset) begin
        m_st[i] = 0; m_e[i] = 0; m_per[i] = 0;
      end else if (abort) begin
        m_st[i] = 0; m_e[i] = 0;
      end else if (m_st[i] == 0 || m_st[i] == 3) begin
        if (start && period_in != 0) begin
          m_per[i] = period_in; m_e[i] = 0; m_st[i] = 1;
        end
      end else if (m_st[i] == 1) begin
        if (hold) m_st[i] = 2;
        else begin
          m_e[i]++;
          if (m_e[i] == m_per[i] * m_div[i]) begin
            m_done[i] = 1'b1;
            if (per_en) m_e[i] = 0;
            else        m_st[i] = 3;
          end
        end
      end else if (!hold) begin
        m_st[i] = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic go_idle();
    abort = 1'b1; start = 1'b0; hold = 1'b0;
    tick();
    abort = 1'b0;
  endtask

  task automatic launch(input logic [7:0] p);
    start = 1'b1; period_in = p;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; period_in = 8'd5;
    tick(); tick();
    n_checks++;
    if ({st1, c1, busy1, done1} !== 12'd0) begin
      $display("FAIL reset_dut1 got state=%0d count=%0d busy=%0d done=%0d want all 0", st1, c1, busy1, done1);
      n_fail++;
    end
    n_checks++;
    if ({st4, c4, busy4, done4} !== 12'd0) begin
      $display("FAIL reset_dut4 got state=%0d count=%0d busy=%0d done=%0d want all 0", st4, c4, busy4, done4);
      n_fail++;
    end
    reset = 1'b0; start = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_one_shot();
    go_idle();
    launch(8'd5);
    n_checks++;
    if (st1 !== 2'd1 || c1 !== 8'd0 || busy1 !== 1'b1) begin
      $display("FAIL oneshot_start got state=%0d count=%0d busy=%0d want 1/0/1", st1, c1, busy1);
      n_fail++;
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++;
      if (c1 !== 8'(k) || done1 !== 1'b0) begin
        $display("FAIL oneshot_count got count=%0d done=%0d want %0d/0", c1, done1, k);
        n_fail++;
      end
    end
    tick();
    n_checks++;
    if (done1 !== 1'b1 || st1 !== 2'd3 || c1 !== 8'd4 || busy1 !== 1'b0) begin
      $display("FAIL oneshot_done got done=%0d state=%0d count=%0d busy=%0d want 1/3/4/0", done1, st1, c1, busy1);
      n_fail++;
    end
    tick();
    n_checks++;
    if (done1 !== 1'b0 || st1 !== 2'd3 || c1 !== 8'd4) begin
      $display("FAIL oneshot_hold_done got done=%0d state=%0d count=%0d want 0/3/4", done1, st1, c1);
      n_fail++;
    end
    $display("test_one_shot done");
  endtask

  task automatic test_prescale();
    go_idle();
    launch(8'd3);
    for (int j = 1; j <= 12; j++) begin
      tick();
      n_checks++;
      if (j < 12) begin
        if (c4 !== 8'(j / 4) || st4 !== 2'd1 || done4 !== 1'b0) begin
          $display("FAIL prescale_step%0d got count=%0d state=%0d done=%0d want %0d/1/0", j, c4, st4, done4, j / 4);
          n_fail++;
        end
      end else if (c4 !== 8'd2 || st4 !== 2'd3 || done4 !== 1'b1) begin
        $display("FAIL prescale_done got count=%0d state=%0d done=%0d want 2/3/1", c4, st4, done4);
        n_fail++;
      end
    end
    $display("test_prescale done");
  endtask

  task automatic test_hold();
    int edges;
    bit seen;
    go_idle();
    launch(8'd10);
    tick(); tick(); tick();
    n_checks++;
    if (c1 !== 8'd3) begin
      $display("FAIL hold_precount got count=%0d want 3", c1);
      n_fail++;
    end
    hold = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      n_checks++;
      if (st1 !== 2'd2 || c1 !== 8'd3 || busy1 !== 1'b1 || done1 !== 1'b0) begin
        $display("FAIL hold_pause got state=%0d count=%0d busy=%0d done=%0d want 2/3/1/0", st1, c1, busy1, done1);
        n_fail++;
      end
    end
    hold = 1'b0;
    edges = 9;
    seen = 1'b0;
    for (int j = 0; j < 40 && !seen; j++) begin
      tick();
      edges++;
      if (done1 === 1'b1) seen = 1'b1;
    end
    // 10 counting edges + 6 held edges + 1 edge spent leaving PAUSE
    n_checks++;
    if (!seen || edges != 17) begin
      $display("FAIL hold_latency got edges=%0d seen=%0d want 17/1", edges, seen);
      n_fail++;
    end
    $display("test_hold done");
  endtask

  task automatic test_abort();
    go_idle();
    launch(8'd10);
    for (int j = 0; j < 7; j++) tick();
    n_checks++;
    if (c1 !== 8'd7) begin
      $display("FAIL abort_precount got count=%0d want 7", c1);
      n_fail++;
    end
    abort = 1'b1; hold = 1'b1; start = 1'b1; period_in = 8'd4;
    tick();
    n_checks++;
    if ({st1, c1, busy1, done1} !== 12'd0 || st4 !== 2'd0) begin
      $display("FAIL abort_idle got state=%0d count=%0d busy=%0d done=%0d st4=%0d want 0", st1, c1, busy1, done1, st4);
      n_fail++;
    end
    abort = 1'b0; hold = 1'b0; period_in = 8'd0;
    tick();
    n_checks++;
    if (st1 !== 2'd0 || done1 !== 1'b0 || st4 !== 2'd0) begin
      $display("FAIL zero_period got state=%0d done=%0d st4=%0d want 0/0/0", st1, done1, st4);
      n_fail++;
    end
    start = 1'b0;
    tick();
    n_checks++;
    if (done1 !== 1'b0 || c1 !== 8'd0) begin
      $display("FAIL zero_period_quiet got done=%0d count=%0d want 0/0", done1, c1);
      n_fail++;
    end
    $display("test_abort done");
  endtask

  task automatic test_back_to_back();
    go_idle();
    launch(8'd1);
    n_checks++;
    if (st1 !== 2'd1 || c1 !== 8'd0) begin
      $display("FAIL p1_start got state=%0d count=%0d want 1/0", st1, c1);
      n_fail++;
    end
    start = 1'b1; period_in = 8'd2;
    tick();
    n_checks++;
    if (done1 !== 1'b1 || st1 !== 2'd3 || c1 !== 8'd0) begin
      $display("FAIL p1_done got done=%0d state=%0d count=%0d want 1/3/0", done1, st1, c1);
      n_fail++;
    end
    tick();
    start = 1'b0;
    n_checks++;
    if (st1 !== 2'd1 || c1 !== 8'd0 || done1 !== 1'b0) begin
      $display("FAIL b2b_reload got state=%0d count=%0d done=%0d want 1/0/0", st1, c1, done1);
      n_fail++;
    end
    tick(); tick();
    n_checks++;
    if (done1 !== 1'b1 || c1 !== 8'd1 || st1 !== 2'd3) begin
      $display("FAIL b2b_done got done=%0d count=%0d state=%0d want 1/1/3", done1, c1, st1);
      n_fail++;
    end
    $display("test_back_to_back done");
  endtask

`ifdef TIMER_AUTORELOAD_EN
  task automatic test_autoreload();
    int e;
    go_idle();
    periodic = 1'b1;
    launch(8'd3);
    for (int j = 1; j <= 6; j++) begin
      tick();
      e = j % 3;
      n_checks++;
      if (c1 !== 8'(e) || done1 !== (e == 0) || st1 !== 2'd1) begin
        $display("FAIL autoreload_step%0d got count=%0d done=%0d state=%0d want %0d/%0d/1", j, c1, done1, st1, e, e == 0);
        n_fail++;
      end
    end
    periodic = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (st1 !== 2'd3 || done1 !== 1'b1 || c1 !== 8'd2) begin
      $display("FAIL autoreload_stop got state=%0d done=%0d count=%0d want 3/1/2", st1, done1, c1);
      n_fail++;
    end
    $display("test_autoreload done");
  endtask
`endif

  task automatic test_random();
    logic [7:0] ec;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      abort = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 5) == 0);
      hold  = !start && ($urandom_range(0, 7) == 0);
      period_in = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
`ifdef TIMER_AUTORELOAD_EN
      periodic = ($urandom_range(0, 3) != 0);
`endif
      tick();
      ec = 8'(exp_count(0));
      n_checks++;
      if (c1 !== ec || st1 !== 2'(m_st[0]) || done1 !== m_done[0] || busy1 !== (m_st[0] == 1 || m_st[0] == 2)) begin
        $display("FAIL random_dut1 cyc%0d got count=%0d state=%0d done=%0d busy=%0d want %0d/%0d/%0d", n, c1, st1, done1, busy1, ec, m_st[0], m_done[0]);
        n_fail++;
      end
      ec = 8'(exp_count(1));
      n_checks++;
      if (c4 !== ec || st4 !== 2'(m_st[1]) || done4 !== m_done[1] || busy4 !== (m_st[1] == 1 || m_st[1] == 2)) begin
        $display("FAIL random_dut4 cyc%0d got count=%0d state=%0d done=%0d busy=%0d want %0d/%0d/%0d", n, c4, st4, done4, busy4, ec, m_st[1], m_done[1]);
        n_fail++;
      end
    end
    reset = 1'b0; abort = 1'b0; start = 1'b0; hold = 1'b0; periodic = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_e[i] = 0; m_per[i] = 0; m_done[i] = 1'b0;
    end
    #1;
    test_reset();
    test_one_shot();
    test_prescale();
    test_hold();
    test_abort();
    test_back_to_back();
`ifdef TIMER_AUTORELOAD_EN
    test_autoreload();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
